// File: rtl/offset_stream_receiver_pkg.sv
// Shared types for the offset stream receiver: data word, idle FSM states,
// and the offset constant the producer adds before transmission.
package offset_stream_receiver_pkg;

   localparam int unsigned WORD_W     = 32;
   localparam int unsigned IDLE_CNT_W = 8;

   typedef logic [WORD_W-1:0] word_t;

   // Must match the producer's encoding offset.
   localparam word_t DEFAULT_OFFSET = 32'd100;

   typedef enum logic [1:0] {
      ACTIVE = 2'd0,
      COUNT  = 2'd1,
      SLEEP  = 2'd2
   } idle_state_e;

endpackage

// File: rtl/offset_rx_fifo.sv
// Synchronous FIFO holding decoded words; head word is presented combinationally.
module offset_rx_fifo
   import offset_stream_receiver_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WORD_W-1:0]        wr_data,
   output logic [WORD_W-1:0]        rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   word_t            mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Storage array; no reset needed since the head is masked while empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign empty   = (count == '0);
   assign full    = (count == CNT_W'(DEPTH));
   assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/offset_stream_receiver.sv
// Receives offset-encoded producer words, decodes and buffers them, and
// optionally requests consumer sleep when idle (macro OFFSET_RX_SLEEP_EN).
module offset_stream_receiver
   import offset_stream_receiver_pkg::*;
#(
   parameter int unsigned DEPTH       = 4,
   parameter word_t       OFFSET      = DEFAULT_OFFSET,
   parameter int unsigned IDLE_THRESH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [31:0]              data_in,
   input  logic                     valid_in,
   input  logic                     ready_in,
   input  logic                     ovf_clr,
   output logic [31:0]              data_out,
   output logic                     valid_out,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic                     sleep_req
);

   if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("DEPTH must be a power of two in 2..16");
   end
   if ((IDLE_THRESH < 2) || (IDLE_THRESH > 255)) begin : g_bad_thresh
      $error("IDLE_THRESH must be in 2..255");
   end

   logic  full;
   logic  empty;
   logic  push;
   logic  pop;
   logic  drop;
   word_t decoded;

   assign decoded   = data_in - OFFSET;
   assign valid_out = ~empty;
   assign pop       = valid_out & ready_in;
   // A full FIFO still accepts a beat when the head leaves in the same cycle.
   assign push      = valid_in & (~full | pop);
   assign drop      = valid_in & full & ~pop;

   offset_rx_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .pop     (pop),
      .wr_data (decoded),
      .rd_data (data_out),
      .full    (full),
      .empty   (empty),
      .count   (occupancy)
   );

   // Sticky drop flag; a new drop wins over a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (ovf_clr) begin
         overflow <= 1'b0;
      end
   end

`ifdef OFFSET_RX_SLEEP_EN
   idle_state_e           state;
   idle_state_e           state_next;
   logic [IDLE_CNT_W-1:0] idle_cnt;
   logic [IDLE_CNT_W-1:0] idle_cnt_next;
   logic                  idle;

   assign idle = empty & ~valid_in;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ACTIVE;
         idle_cnt  <= '0;
         sleep_req <= 1'b0;
      end else begin
         state     <= state_next;
         idle_cnt  <= idle_cnt_next;
         sleep_req <= (state_next == SLEEP);
      end
   end

   // Idle counter tracks consecutive idle cycles including the ACTIVE exit cycle.
   always_comb begin
      state_next    = state;
      idle_cnt_next = idle_cnt;
      case (state)
         ACTIVE: begin
            if (idle) begin
               state_next    = COUNT;
               idle_cnt_next = IDLE_CNT_W'(1);
            end
         end
         COUNT: begin
            if (!idle) begin
               state_next    = ACTIVE;
               idle_cnt_next = '0;
            end else begin
               idle_cnt_next = idle_cnt + IDLE_CNT_W'(1);
               if (idle_cnt_next >= IDLE_CNT_W'(IDLE_THRESH)) begin
                  state_next = SLEEP;
               end
            end
         end
         SLEEP: begin
            if (!idle) begin
               state_next    = ACTIVE;
               idle_cnt_next = '0;
            end
         end
         default: begin
            state_next    = ACTIVE;
            idle_cnt_next = '0;
         end
      endcase
   end
`else
   assign sleep_req = 1'b0;
`endif

endmodule

// File: tb/tb_offset_stream_receiver.sv
// Self-checking bench for offset_stream_receiver: constant vector table,
// directed sleep/reset sequences, and randomized traffic against a queue model.
module tb_offset_stream_receiver;

   localparam int unsigned DEPTH       = 4;
   localparam int unsigned OCC_W       = $clog2(DEPTH) + 1;
   localparam logic [31:0] OFFSET      = 32'd100;
   localparam int unsigned IDLE_THRESH = 16;

   logic             clk;
   logic             rst_n;
   logic [31:0]      data_in;
   logic             valid_in;
   logic             ready_in;
   logic             ovf_clr;
   logic [31:0]      data_out;
   logic             valid_out;
   logic             overflow;
   logic [OCC_W-1:0] occupancy;
   logic             sleep_req;

   offset_stream_receiver #(
      .DEPTH       (DEPTH),
      .OFFSET      (OFFSET),
      .IDLE_THRESH (IDLE_THRESH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .data_in   (data_in),
      .valid_in  (valid_in),
      .ready_in  (ready_in),
      .ovf_clr   (ovf_clr),
      .data_out  (data_out),
      .valid_out (valid_out),
      .overflow  (overflow),
      .occupancy (occupancy),
      .sleep_req (sleep_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks;
   int failures;

   // Reference model: FIFO contents, sticky flag, consecutive idle count.
   logic [31:0] mq[$];
   bit          m_ovf;
   bit          m_sleep;
   int          m_idle;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_ovf   = 1'b0;
      m_sleep = 1'b0;
      m_idle  = 0;
   endtask

   // Advance the model by one clock using the inputs currently driven.
   task automatic model_step();
      bit pop_m;
      bit full_m;
      bit idle_m;
      pop_m  = (mq.size() > 0) && ready_in;
      full_m = (mq.size() == DEPTH);
      idle_m = (mq.size() == 0) && !valid_in;
      if (pop_m) void'(mq.pop_front());
      if (valid_in && (!full_m || pop_m)) mq.push_back(data_in - OFFSET);
      if (valid_in && full_m && !pop_m) m_ovf = 1'b1;
      else if (ovf_clr)                 m_ovf = 1'b0;
`ifdef OFFSET_RX_SLEEP_EN
      if (m_sleep) begin
         if (!idle_m) begin
            m_sleep = 1'b0;
            m_idle  = 0;
         end
      end else if (idle_m) begin
         m_idle++;
         if (m_idle >= IDLE_THRESH) m_sleep = 1'b1;
      end else begin
         m_idle = 0;
      end
`else
      m_sleep = 1'b0;
`endif
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] d, input bit v, input bit r, input bit c);
      data_in  = d;
      valid_in = v;
      ready_in = r;
      ovf_clr  = c;
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_valid"}, 32'(valid_out), 32'(mq.size() > 0));
      chk({tag, "_occ"},   32'(occupancy), 32'(mq.size()));
      chk({tag, "_ovf"},   32'(overflow),  32'(m_ovf));
      chk({tag, "_sleep"}, 32'(sleep_req), 32'(m_sleep));
      if (mq.size() > 0) chk({tag, "_data"}, data_out, mq[0]);
   endtask

   typedef struct {
      logic [31:0] din;
      bit          v;
      bit          r;
      bit          clr;
      bit          e_valid;
      logic [31:0] e_data;
      int          e_occ;
      bit          e_ovf;
   } vec_t;

   vec_t tbl[21];

   initial begin
      checks   = 0;
      failures = 0;
      model_reset();
      rst_n = 1'b0;
      drive(32'd0, 1'b0, 1'b0, 1'b0);

      tbl[0]  = '{32'd200,  1, 1, 0, 1, 32'd100,       1, 0};
      tbl[1]  = '{32'd0,    0, 1, 0, 0, 32'd0,         0, 0};
      tbl[2]  = '{32'd5,    1, 1, 0, 1, 32'hFFFF_FFA1, 1, 0};
      tbl[3]  = '{32'd0,    0, 1, 0, 0, 32'd0,         0, 0};
      tbl[4]  = '{32'd1100, 1, 0, 0, 1, 32'd1000,      1, 0};
      tbl[5]  = '{32'd1200, 1, 0, 0, 1, 32'd1000,      2, 0};
      tbl[6]  = '{32'd1300, 1, 0, 0, 1, 32'd1000,      3, 0};
      tbl[7]  = '{32'd1400, 1, 0, 0, 1, 32'd1000,      4, 0};
      tbl[8]  = '{32'd1500, 1, 0, 0, 1, 32'd1000,      4, 1};
      tbl[9]  = '{32'd0,    0, 1, 1, 1, 32'd1100,      3, 0};
      tbl[10] = '{32'd0,    0, 1, 0, 1, 32'd1200,      2, 0};
      tbl[11] = '{32'd1600, 1, 0, 0, 1, 32'd1200,      3, 0};
      tbl[12] = '{32'd1700, 1, 0, 0, 1, 32'd1200,      4, 0};
      tbl[13] = '{32'd2000, 1, 0, 1, 1, 32'd1200,      4, 1};
      tbl[14] = '{32'd0,    0, 0, 1, 1, 32'd1200,      4, 0};
      tbl[15] = '{32'd1800, 1, 1, 0, 1, 32'd1300,      4, 0};
      tbl[16] = '{32'd1900, 1, 1, 0, 1, 32'd1500,      4, 0};
      tbl[17] = '{32'd0,    0, 1, 0, 1, 32'd1600,      3, 0};
      tbl[18] = '{32'd0,    0, 1, 0, 1, 32'd1700,      2, 0};
      tbl[19] = '{32'd0,    0, 1, 0, 1, 32'd1800,      1, 0};
      tbl[20] = '{32'd0,    0, 1, 0, 0, 32'd0,         0, 0};

      // Reset state
      #1;
      chk("rst_valid", 32'(valid_out), 32'd0);
      chk("rst_occ",   32'(occupancy), 32'd0);
      chk("rst_ovf",   32'(overflow),  32'd0);
      chk("rst_sleep", 32'(sleep_req), 32'd0);
      chk("rst_data",  data_out,       32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Vector table
      for (int i = 0; i < 21; i++) begin
         drive(tbl[i].din, tbl[i].v, tbl[i].r, tbl[i].clr);
         tick();
         chk($sformatf("vec%0d_valid", i), 32'(valid_out), 32'(tbl[i].e_valid));
         chk($sformatf("vec%0d_occ", i),   32'(occupancy), 32'(tbl[i].e_occ));
         chk($sformatf("vec%0d_ovf", i),   32'(overflow),  32'(tbl[i].e_ovf));
         if (tbl[i].e_valid) chk($sformatf("vec%0d_data", i), data_out, tbl[i].e_data);
      end
      check_model("post_tbl");

      // Idle sleep sequence
      drive(32'd0, 1'b0, 1'b1, 1'b0);
`ifdef OFFSET_RX_SLEEP_EN
      for (int i = 0; i < int'(IDLE_THRESH) - 1; i++) tick();
      chk("sleep_before_thresh", 32'(sleep_req), 32'd0);
      tick();
      chk("sleep_at_thresh", 32'(sleep_req), 32'd1);
      check_model("sleep");
      drive(32'd101, 1'b1, 1'b1, 1'b0);
      tick();
      chk("wake_sleep", 32'(sleep_req), 32'd0);
      chk("wake_valid", 32'(valid_out), 32'd1);
      chk("wake_data",  data_out,       32'd1);
      drive(32'd0, 1'b0, 1'b1, 1'b0);
      tick();
      chk("wake_drain", 32'(valid_out), 32'd0);
`else
      for (int i = 0; i < int'(IDLE_THRESH) + 4; i++) tick();
      chk("no_sleep_feature", 32'(sleep_req), 32'd0);
`endif
      check_model("post_sleep");

      // Reset mid-stream with three entries and overflow set
      for (int i = 0; i < 5; i++) begin
         drive(32'd300 + 32'(i), 1'b1, 1'b0, 1'b0);
         tick();
      end
      drive(32'd0, 1'b0, 1'b1, 1'b0);
      tick();
      chk("pre_rst_occ", 32'(occupancy), 32'd3);
      chk("pre_rst_ovf", 32'(overflow),  32'd1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(valid_out), 32'd0);
      chk("async_rst_occ",   32'(occupancy), 32'd0);
      chk("async_rst_ovf",   32'(overflow),  32'd0);
      chk("async_rst_data",  data_out,       32'd0);
      model_reset();
      drive(32'd777, 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      chk("rst_edge_no_push", 32'(occupancy), 32'd0);
      rst_n = 1'b1;
      drive(32'd0, 1'b0, 1'b0, 1'b0);
      tick();
      check_model("post_rst");

      // Randomized traffic in phases of differing beat density
      for (int ph = 0; ph < 4; ph++) begin
         int dens;
         dens = (ph == 0) ? 60 : (ph == 1) ? 3 : (ph == 2) ? 90 : 0;
         for (int c = 0; c < 100; c++) begin
            drive($urandom(),
                  ($urandom_range(0, 99) < dens),
                  ($urandom_range(0, 99) < 50),
                  ($urandom_range(0, 99) < 10));
            tick();
            check_model($sformatf("rnd%0d", ph));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
